pipe_ctrl_unit: RTL
===================

# pipe_ctrl_unit

Pipelined successor to the single-cycle opcode decoder for the 5-stage MIPS datapath. It decodes the ID-stage opcode into EX/M/WB control bundles and carries them through its own ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, inserts bubbles, and flushes on a taken branch. A saturating stall counter and a sticky illegal-opcode flag support debug.

## Interface
- OP_W, 6, opcode width
- REG_W, 5, register-address width
- STALL_CNT_W, 16, stall-counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- ifid_opcode  in  OP_W  opcode of the instruction in IF/ID
- ifid_rs  in  REG_W  rs field of the instruction in IF/ID
- ifid_rt  in  REG_W  rt field of the instruction in IF/ID
- branch_taken  in  1  from datapath: EX/MEM Branch & ALU zero
- ex_ctrl  out  4  ID/EX bundle {RegDst, ALUOp[1:0], ALUSrc}
- mem_ctrl  out  3  EX/MEM bundle {Branch, MemRead, MemWrite}
- wb_ctrl  out  2  MEM/WB bundle {RegWrite, MemtoReg}
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on the next edge
- jump  out  1  jump redirect (CTRL_JUMP_EN only; otherwise tied 0)
- illegal_op  out  1  sticky, unrecognised opcode seen
- stall_count  out  STALL_CNT_W  number of stall cycles, saturating

## Operation
- **Decode (combinational, ID stage).** Each entry lists EX/M/WB.
  - RTYPE 000000: 1100/000/10
  - LW 100011: 0001/010/11
  - SW 101011: 0001/001/00
  - BEQ 000100: 0010/100/00
  - NOP 100000: 1000/000/00
  - Don't-cares are driven 0, never Z.
- **Unrecognised opcode.** Decodes to the all-zero bundle and sets illegal_op on the next edge. illegal_op stays set until reset.
- **ID/EX register.** Holds the full bundle plus ifid_rt (as idex_rt).
- **EX/MEM register.** Holds M and WB.
- **MEM/WB register.** Holds WB.
- **Load-use hazard (combinational).** Hazard = ID/EX MemRead & idex_rt≠0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- **On hazard.**
  - pc_write=0 and ifid_write=0.
  - The all-zero bundle is loaded into ID/EX.
  - stall_count increments, saturating at all-ones.
- **On branch_taken.**
  - ifid_flush=1.
  - ID/EX and EX/MEM load the all-zero bundle.
  - pc_write=1 and ifid_write=1.
- **Hazard and branch_taken in the same cycle.** Flush wins: no stall is taken and the counter does not increment.
- **Otherwise.** pc_write=ifid_write=1, ifid_flush=0, and the control registers advance normally.

## Timing
- **Reset.** On an edge with rst_n=0, the following are zeroed: all control registers, idex_rt, illegal_op and stall_count. ex_ctrl/mem_ctrl/wb_ctrl therefore read 0 after that edge.
  - While rst_n=0: pc_write=ifid_write=0, ifid_flush=0, jump=0.
  - Reset asserted mid-stream discards all in-flight bundles.
- **Latency.** The decoded bundle appears on ex_ctrl 1 cycle after being presented in ID, on mem_ctrl after 2 cycles, and on wb_ctrl after 3.
- **Combinational outputs.** pc_write, ifid_write, ifid_flush and jump are combinational in the current cycle.
- **Stall length.** A load-use stall lasts exactly 1 cycle: the bubble clears MemRead in ID/EX, so the hazard deasserts.
- **Back-to-back LW.** Dependent back-to-back LW instructions each produce one stall.

## Configuration
- **CTRL_JUMP_EN defined.** Opcode 000010 (J) decodes to the all-zero bundle, drives jump=1 and ifid_flush=1 in the same cycle, and is not illegal.
  - branch_taken in the same cycle takes priority: jump=0, and the branch flush applies.
- **CTRL_JUMP_EN undefined.** 000010 is illegal and jump is constant 0.

## Structure
- **Shared package (ctrl_pkg).** Holds:
  - opcode constants RTYPE/LW/SW/BEQ/NOP/J;
  - bundle widths and bit-index constants (RegDst, ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg);
  - the all-zero bundle constant.
- **Sub-module ctrl_decode.** The combinational opcode → {EX, M, WB, illegal, jump} decoder. The pipeline registers, hazard logic and counters stay in pipe_ctrl_unit.

## Test plan
- **Decode latency.** Reset, then RTYPE in ID -> ex_ctrl=1100 next cycle, mem_ctrl=000 at +2, wb_ctrl=10 at +3.
- **Load-use stall.** LW with rt=5, then an instruction with rs=5 -> one cycle of pc_write=ifid_write=0, ex_ctrl=0000 bubble, stall_count=1.
- **No stall on $0.** LW with rt=0 followed by rs=0 -> no stall, stall_count stays 0.
- **Flush beats stall.** branch_taken=1 in the same cycle as a hazard -> ifid_flush=1, ex_ctrl=0000 and mem_ctrl=000 next cycle, pc_write=1, stall_count unchanged.
- **Illegal opcode and reset.** Opcode 111111 -> zero bundle, illegal_op=1 and held. rst_n=0 mid-pipeline -> all outputs 0 after the edge.
- **Saturation and jump.** With STALL_CNT_W=2, four stalls -> stall_count=3. With CTRL_JUMP_EN, opcode 000010 -> jump=1, ifid_flush=1, illegal_op=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_pkg : opcodes, control-bundle layout and constants shared by  |
// |            the pipelined MIPS control unit. Option: CTRL_JUMP_EN   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [5:0] c_opc_rtype = 6'b000000;
  localparam logic [5:0] c_opc_lw    = 6'b100011;
  localparam logic [5:0] c_opc_sw    = 6'b101011;
  localparam logic [5:0] c_opc_beq   = 6'b000100;
  localparam logic [5:0] c_opc_nop   = 6'b100000;
  localparam logic [5:0] c_opc_j     = 6'b000010;

  localparam int c_ex_w     = 4;
  localparam int c_m_w      = 3;
  localparam int c_wb_w     = 2;
  localparam int c_bundle_w = c_ex_w + c_m_w + c_wb_w;

  localparam int c_ex_regdst   = 3;
  localparam int c_ex_aluop_hi = 2;
  localparam int c_ex_aluop_lo = 1;
  localparam int c_ex_alusrc   = 0;
  localparam int c_m_branch    = 2;
  localparam int c_m_memread   = 1;
  localparam int c_m_memwrite  = 0;
  localparam int c_wb_regwrite = 1;
  localparam int c_wb_memtoreg = 0;

  typedef struct packed {
    logic [c_ex_w-1:0] ex;
    logic [c_m_w-1:0]  m;
    logic [c_wb_w-1:0] wb;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t c_bundle_zero = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_decode : combinational opcode -> {EX, M, WB, illegal, jump}.  |
// |               Option: CTRL_JUMP_EN makes J legal and drives jump.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0]       opcode,
  output logic [c_bundle_w-1:0] bundle,
  output logic                  illegal,
  output logic                  jump
);

  ctrl_bundle_t w_b;

  always_comb begin
    w_b     = c_bundle_zero;
    illegal = 1'b0;
    jump    = 1'b0;
    case (opcode)
      OP_W'(c_opc_rtype): begin
        w_b.ex[c_ex_regdst]    = 1'b1;
        w_b.ex[c_ex_aluop_hi]  = 1'b1;
        w_b.wb[c_wb_regwrite]  = 1'b1;
      end
      OP_W'(c_opc_lw): begin
        w_b.ex[c_ex_alusrc]    = 1'b1;
        w_b.m[c_m_memread]     = 1'b1;
        w_b.wb[c_wb_regwrite]  = 1'b1;
        w_b.wb[c_wb_memtoreg]  = 1'b1;
      end
      OP_W'(c_opc_sw): begin
        w_b.ex[c_ex_alusrc]    = 1'b1;
        w_b.m[c_m_memwrite]    = 1'b1;
      end
      OP_W'(c_opc_beq): begin
        w_b.ex[c_ex_aluop_lo]  = 1'b1;
        w_b.m[c_m_branch]      = 1'b1;
      end
      OP_W'(c_opc_nop): begin
        w_b.ex[c_ex_regdst]    = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      OP_W'(c_opc_j): jump = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign bundle = w_b;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_unit : ID/EX, EX/MEM, MEM/WB control pipeline with       |
// |                  load-use stall, branch flush and debug counters.  |
// |                  Option: CTRL_JUMP_EN enables the J redirect.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_W-1:0]        ifid_opcode,
  input  logic [REG_W-1:0]       ifid_rs,
  input  logic [REG_W-1:0]       ifid_rt,
  input  logic                   branch_taken,
  output logic [3:0]             ex_ctrl,
  output logic [2:0]             mem_ctrl,
  output logic [1:0]             wb_ctrl,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   jump,
  output logic                   illegal_op,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [c_bundle_w-1:0]  w_dec_raw;
  ctrl_bundle_t           w_dec;
  logic                   w_dec_illegal;
  logic                   w_dec_jump;
  logic                   w_hazard;
  logic                   w_stall;
  logic                   w_jump;

  ctrl_bundle_t           r_idex;
  logic [REG_W-1:0]       r_idex_rt;
  logic [c_m_w-1:0]       r_exmem_m;
  logic [c_wb_w-1:0]      r_exmem_wb;
  logic [c_wb_w-1:0]      r_memwb_wb;
  logic                   r_illegal;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .opcode  (ifid_opcode),
    .bundle  (w_dec_raw),
    .illegal (w_dec_illegal),
    .jump    (w_dec_jump)
  );

  assign w_dec = w_dec_raw;

  assign w_hazard = r_idex.m[c_m_memread] && (r_idex_rt != '0) &&
                    ((r_idex_rt == ifid_rs) || (r_idex_rt == ifid_rt));
  // A taken branch squashes the dependent instruction, so no stall is needed.
  assign w_stall  = w_hazard && !branch_taken;

`ifdef CTRL_JUMP_EN
  // A stalled J waits in IF/ID and redirects once the hazard clears.
  assign w_jump = w_dec_jump && !branch_taken && !w_stall;
`else
  logic w_unused_jump;
  assign w_unused_jump = w_dec_jump;
  assign w_jump        = 1'b0;
`endif

  assign pc_write   = rst_n && !w_stall;
  assign ifid_write = rst_n && !w_stall;
  assign ifid_flush = rst_n && (branch_taken || w_jump);
  assign jump       = rst_n && w_jump;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex      <= c_bundle_zero;
      r_idex_rt   <= '0;
      r_exmem_m   <= '0;
      r_exmem_wb  <= '0;
      r_memwb_wb  <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_idex     <= (w_stall || branch_taken) ? c_bundle_zero : w_dec;
      r_idex_rt  <= ifid_rt;
      r_exmem_m  <= branch_taken ? '0 : r_idex.m;
      r_exmem_wb <= branch_taken ? '0 : r_idex.wb;
      r_memwb_wb <= r_exmem_wb;
      if (w_dec_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  assign ex_ctrl     = r_idex.ex;
  assign mem_ctrl    = r_exmem_m;
  assign wb_ctrl     = r_memwb_wb;
  assign illegal_op  = r_illegal;
  assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire
